// File: rtl/nn_pkg.sv
// Shared types and default sizes for the classification back end.
package nn_pkg;

    localparam int CLASSES_DEF = 10;
    localparam int SCORE_W_DEF = 8;
    localparam int IDX_W_DEF   = 8;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pred_state_t;

    typedef logic [SCORE_W_DEF-1:0] score_t;

endpackage

// File: rtl/prediction_controller_if.sv
// Result-buffer read port plus the prediction valid/ready output.
interface prediction_controller_if #(
    parameter int SCORE_W = nn_pkg::SCORE_W_DEF,
    parameter int IDX_W   = nn_pkg::IDX_W_DEF
) ();

    logic               rd_en;
    logic [IDX_W-1:0]   rd_addr;
    logic [SCORE_W-1:0] rd_data;
    logic               pred_valid;
    logic               pred_ready;
    logic [IDX_W-1:0]   pred_class;
    logic [SCORE_W-1:0] pred_score;

    modport master (
        output rd_en, rd_addr, pred_valid, pred_class, pred_score,
        input  rd_data, pred_ready
    );

    modport slave (
        input  rd_en, rd_addr, pred_valid, pred_class, pred_score,
        output rd_data, pred_ready
    );

endinterface

// File: rtl/argmax_accum.sv
// Running argmax over a stream of tagged scores. The first element of a
// pass loads unconditionally; later elements win only on a strictly greater
// score, so ties resolve to the lowest index.
module argmax_accum #(
    parameter int SCORE_W = 8,
    parameter int IDX_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_first,
    input  logic               data_valid,
    input  logic [SCORE_W-1:0] data,
    input  logic [IDX_W-1:0]   idx,
    output logic [SCORE_W-1:0] max,
    output logic [IDX_W-1:0]   max_idx
);

    logic [SCORE_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    // Single shared comparator: take the new element on first-of-pass or strict win.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (data_valid && (clr_first || (data > max_q))) begin
            max_d = data;
            idx_d = idx;
        end
    end

    // Best-so-far registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    assign max     = max_q;
    assign max_idx = idx_q;

endmodule

// File: rtl/prediction_controller.sv
// Walks the result buffer one class per cycle, keeps a running argmax and
// offers the winner on a valid/ready port. Counts accepted predictions.
module prediction_controller
    import nn_pkg::*;
#(
    parameter int CLASSES = CLASSES_DEF,
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic [CNT_W-1:0]        img_count,
    prediction_controller_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASSES - 1);

    pred_state_t        state_q, state_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // One-stage tag that lines the address up with the buffer's read data.
    logic               tag_vld_q;
    logic [IDX_W-1:0]   tag_idx_q;

    logic               rd_en;
    logic               hs;
    logic [SCORE_W-1:0] acc_max;
    logic [IDX_W-1:0]   acc_idx;

    assign rd_en = (state_q == READ);
    assign hs    = (state_q == DONE) && bus.pred_ready;

    // Next-state, address counter and completion counter.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    addr_d  = '0;
                end
            end
            READ: begin
                if (addr_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (hs) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tag the outstanding read so the returning data knows its class index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= 1'b0;
            tag_idx_q <= '0;
        end else begin
            tag_vld_q <= rd_en;
            tag_idx_q <= addr_q;
        end
    end

    argmax_accum #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_first  (tag_idx_q == '0),
        .data_valid (tag_vld_q),
        .data       (bus.rd_data),
        .idx        (tag_idx_q),
        .max        (acc_max),
        .max_idx    (acc_idx)
    );

    // The accumulator is idle outside READ/DRAIN, so its registers double as
    // the held prediction through DONE and the following IDLE.
    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = addr_q;
    assign bus.pred_valid = (state_q == DONE);
    assign bus.pred_class = acc_idx;
    assign bus.pred_score = acc_max;
    assign busy           = (state_q != IDLE);
    assign img_count      = cnt_q;

endmodule

// File: tb/tb_prediction_controller.sv
// Scoreboard bench: stimulus pushes the reference argmax for each run, a
// negedge monitor pops and compares on every prediction handshake.
module tb_prediction_controller;
    import nn_pkg::*;

    localparam int C  = 10;
    localparam int SW = 8;
    localparam int IW = 8;
    localparam int CW = 4;

    typedef struct {
        int cls;
        int score;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic [CW-1:0] img_count;

    prediction_controller_if #(.SCORE_W(SW), .IDX_W(IW)) bus ();

    prediction_controller #(
        .CLASSES (C),
        .SCORE_W (SW),
        .IDX_W   (IW),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .img_count (img_count),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    score_t mem [C];
    exp_t   exp_q [$];
    exp_t   mon_e;
    int     vectors = 0;
    int     errors  = 0;
    int     exp_cnt = 0;

    // Result buffer: 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en && int'(bus.rd_addr) < C) bus.rd_data <= mem[int'(bus.rd_addr)];
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: find the largest value, then the first class holding it.
    function automatic exp_t ref_argmax();
        exp_t r;
        int   best = 0;
        for (int i = 0; i < C; i++) if (int'(mem[i]) > best) best = int'(mem[i]);
        r.cls = 0;
        for (int i = C - 1; i >= 0; i--) if (int'(mem[i]) == best) r.cls = i;
        r.score = best;
        return r;
    endfunction

    // Monitor: every accepted prediction must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cnt = 0;
        end else if (bus.pred_valid && bus.pred_ready) begin
            check("count_at_hs", int'(img_count), exp_cnt);
            if (exp_q.size() == 0) begin
                check("unexpected_pred", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pred_class", int'(bus.pred_class), mon_e.cls);
                check("pred_score", int'(bus.pred_score), mon_e.score);
            end
            exp_cnt = (exp_cnt + 1) % (1 << CW);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        if (busy) check("idle_timeout", int'(busy), 0);
    endtask

    task automatic fill_random(input bit narrow);
        for (int i = 0; i < C; i++)
            mem[i] = narrow ? score_t'($urandom_range(0, 7)) : score_t'($urandom_range(0, 255));
    endtask

    // One inference: issue start, check the read sweep, latency, stall
    // behaviour and return to idle. Optional start noise while busy.
    task automatic do_run(input int stall, input bit noise);
        exp_t e;
        wait_idle();
        e = ref_argmax();
        exp_q.push_back(e);
        bus.pred_ready = (stall == 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < C; k++) begin
            check("rd_en", int'(bus.rd_en), 1);
            check("rd_addr", int'(bus.rd_addr), k);
            start = noise && ($urandom_range(0, 2) == 0);
            step();
        end
        start = 1'b0;
        check("drain_rd_en", int'(bus.rd_en), 0);
        check("drain_valid", int'(bus.pred_valid), 0);
        step();
        check("latency_valid", int'(bus.pred_valid), 1);
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", int'(bus.pred_valid), 1);
            check("stall_class", int'(bus.pred_class), e.cls);
            check("stall_score", int'(bus.pred_score), e.score);
            check("stall_rd_en", int'(bus.rd_en), 0);
            start = noise && ($urandom_range(0, 1) == 0);
            step();
        end
        bus.pred_ready = 1'b1;
        start = noise;
        step();
        start = 1'b0;
        check("post_busy", int'(busy), 0);
        check("post_rd_en", int'(bus.rd_en), 0);
        check("post_valid", int'(bus.pred_valid), 0);
        check("hold_class", int'(bus.pred_class), e.cls);
    endtask

    initial begin
        bus.pred_ready = 1'b1;
        for (int i = 0; i < C; i++) mem[i] = '0;
        step();
        step();
        check("rst_busy", int'(busy), 0);
        check("rst_rd_en", int'(bus.rd_en), 0);
        check("rst_rd_addr", int'(bus.rd_addr), 0);
        check("rst_valid", int'(bus.pred_valid), 0);
        check("rst_class", int'(bus.pred_class), 0);
        check("rst_score", int'(bus.pred_score), 0);
        check("rst_count", int'(img_count), 0);
        rst_n = 1'b1;
        step();

        // Basic sweep
        mem = '{3, 9, 1, 200, 4, 7, 0, 5, 2, 8};
        do_run(0, 1'b0);
        // Ties, all zero, max in last slot
        mem = '{5, 50, 50, 1, 50, 0, 0, 0, 0, 0};
        do_run(0, 1'b0);
        mem = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        do_run(0, 1'b0);
        mem = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 255};
        do_run(0, 1'b0);
        // Backpressure with start noise
        fill_random(1'b0);
        do_run(20, 1'b1);
        // Start noise during READ and on the handshake, then immediate restart
        fill_random(1'b1);
        do_run(0, 1'b1);
        fill_random(1'b0);
        do_run(0, 1'b0);
        // Random mix
        for (int r = 0; r < 25; r++) begin
            fill_random($urandom_range(0, 1) == 1);
            do_run($urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of READ
        wait_idle();
        mem = '{10, 20, 250, 30, 40, 50, 60, 70, 80, 90};
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_rd_en", int'(bus.rd_en), 0);
        check("abort_rd_addr", int'(bus.rd_addr), 0);
        check("abort_valid", int'(bus.pred_valid), 0);
        check("abort_class", int'(bus.pred_class), 0);
        check("abort_score", int'(bus.pred_score), 0);
        check("abort_count", int'(img_count), 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        mem = '{4, 1, 2, 3, 0, 4, 1, 2, 3, 1};
        do_run(0, 1'b0);

        // Counter wrap: 15 completions since reset, then one more wraps to 0
        for (int r = 0; r < 14; r++) begin
            fill_random(1'b1);
            do_run(0, 1'b0);
        end
        check("count_15", int'(img_count), 15);
        fill_random(1'b0);
        do_run(1, 1'b0);
        check("count_wrap", int'(img_count), 0);

        repeat (3) step();
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/prediction_controller.md
Name: prediction_controller

Overview:
Sequences the final classification step after the output layer has written its CLASSES scores into the result buffer. On a start pulse it reads the buffer index by index through a 1-cycle-latency read port and keeps a running argmax. It then presents the winning class and score on a valid/ready output and counts completed inferences. It replaces the combinational argmax in the top level, so one comparator is shared across all classes instead of a CLASSES-wide compare chain.

Parameters:
CLASSES, 10, number of output classes (2..255)
SCORE_W, 8, score width; scores are unsigned
IDX_W, 8, class index / read address width
CNT_W, 16, completed-inference counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to evaluate the buffer; honoured only in IDLE
busy  out  1  high in every state except IDLE
rd_en  out  1  read strobe to result buffer
rd_addr  out  IDX_W  class index being read
rd_data  in  SCORE_W  buffer data, valid the cycle after rd_en
pred_valid  out  1  prediction available
pred_ready  in  1  consumer accepts prediction
pred_class  out  IDX_W  winning class index
pred_score  out  SCORE_W  winning score
img_count  out  CNT_W  number of completed pred handshakes

Behaviour:
- Reset, asynchronous, active-low: state=IDLE; busy, rd_en, pred_valid=0; rd_addr, pred_class, pred_score, img_count=0; internal max, idx and valid-pipe registers=0.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: if start is high at edge t, go to READ. start in any other state is ignored and not queued.
- READ: rd_en=1 and rd_addr=0,1,…,CLASSES-1 on cycles t+1 … t+CLASSES. After issuing address CLASSES-1, go to DRAIN.
- Compare pipeline: a registered copy of rd_en/rd_addr tags rd_data one cycle later.
  - Tagged index 0 loads max/idx unconditionally.
  - Later indices replace max/idx only if rd_data > max (strict, unsigned), so ties keep the lowest index.
- DRAIN: one cycle consuming the last read data; rd_en=0. Then go to DONE with pred_class/pred_score loaded from max/idx.
- DONE: pred_valid=1 from cycle t+CLASSES+2 (latency CLASSES+2 from start edge). Outputs stay stable while pred_ready=0.
  - When pred_valid and pred_ready are both high: img_count+1 (wraps at 2^CNT_W), pred_valid drops next cycle, return to IDLE.
- pred_class/pred_score hold their last values while in IDLE.
- A start high in the same cycle as the DONE handshake is ignored; the next start is accepted from IDLE one cycle later.
- rd_addr holds CLASSES-1 after READ; rd_en alone qualifies reads.
- Reset mid-operation aborts immediately to reset values. Buffer contents are not touched; the block only reads.
- Throughput: one inference per CLASSES+3 cycles when pred_ready is held high.

Decomposition:
- Shared package nn_pkg:
  - CLASSES, SCORE_W, IDX_W defaults
  - pred_state_t enum {IDLE, READ, DRAIN, DONE}
  - typedef score_t as logic[SCORE_W-1:0]
- One natural sub-module: argmax_accum. It holds the registered max/idx with inputs clear-on-first, data_valid, data, idx and outputs max, max_idx.
- The FSM, address counter and handshake stay in prediction_controller.

Test Plan:
1. Buffer {3,9,1,200,4,7,0,5,2,8}, start, pred_ready=1 → rd_addr 0..9 on cycles 1..10; pred_valid at cycle 12 with class 3, score 200; img_count 0→1; busy low at cycle 13.
2. Ties: buffer {5,50,50,1,50,0,0,0,0,0} → class 1, score 50. All-zero buffer → class 0, score 0. Max at index 9 (=255) → class 9.
3. Backpressure: pred_ready=0 for 20 cycles after pred_valid → class/score/valid stable, start pulses ignored, no rd_en. Raise pred_ready → one handshake, img_count+1.
4. start asserted in READ and in DONE with the handshake → no restart, no extra rd_en. A start in the following IDLE cycle runs normally.
5. rst_n low at cycle 5 of READ → all outputs zero asynchronously. After release, a fresh start gives a correct result with no leftover max from the aborted run.
6. Set img_count to 65535 via 65535 back-to-back runs (or the CNT_W=4 variant with 15 runs) → the next handshake wraps it to 0.
